shift_rotate_pipe: RTL and testbench

Parametrised, fully pipelined shift/rotate unit for the execute stage. It replaces the single-cycle 16-bit rotate-left datapath with one registered stage per shift-amount bit. It supports rotate left/right, logical shift left/right, and arithmetic shift right. Valid/ready handshakes on both sides, backpressure stalls the whole pipe, and a sideband tag travels with each operation.

---
 rtl/shift_rotate_pkg.sv | 14 +
 rtl/shift_rotate_stage.sv | 29 ++
 rtl/shift_rotate_pipe.sv | 107 ++++++++++
 tb/tb_shift_rotate_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_rotate_pkg.sv
// Shared op-code encoding and helpers for the pipelined shift/rotate unit.
package shift_rotate_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_SRA;
  endfunction

endpackage

// File: rtl/shift_rotate_stage.sv
// One combinational move of AMT positions; passes data through when bit_en is low.
module shift_rotate_stage
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  input  logic             i_sign,
  input  logic             i_bit_en,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_bit_en) begin
      case (i_op)
        OP_ROL:  o_data = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
        OP_SLL:  o_data = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
        OP_ROR:  o_data = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
        OP_SRL:  o_data = {{AMT{1'b0}}, i_data[WIDTH-1:AMT]};
        OP_SRA:  o_data = {{AMT{i_sign}}, i_data[WIDTH-1:AMT]};
        default: o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: one registered stage per shift-amount bit with a
// valid/advance chain so backpressure stalls the whole pipe without loss.
module shift_rotate_pipe
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [CNT_W-1:0] r_v;
  logic [CNT_W-1:0] w_adv;
  logic [CNT_W-1:0] r_err;
  logic [WIDTH-1:0] r_data [CNT_W];
  logic [2:0]       r_op   [CNT_W];
  logic [CNT_W-1:0] r_cnt  [CNT_W];
  logic [TAG_W-1:0] r_tag  [CNT_W];
  logic             r_sign [CNT_W];

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_moved;
    logic [2:0]       w_op;
    logic [CNT_W-1:0] w_cnt;
    logic [TAG_W-1:0] w_tag;
    logic             w_v;
    logic             w_err;
    logic             w_sign;

    if (k == 0) begin : g_first
      assign w_src  = in_data;
      assign w_op   = in_op;
      assign w_cnt  = in_cnt;
      assign w_tag  = in_tag;
      assign w_v    = in_valid;
      assign w_err  = is_reserved(in_op);
      assign w_sign = in_data[WIDTH-1];
    end else begin : g_next
      assign w_src  = r_data[k-1];
      assign w_op   = r_op[k-1];
      assign w_cnt  = r_cnt[k-1];
      assign w_tag  = r_tag[k-1];
      assign w_v    = r_v[k-1];
      assign w_err  = r_err[k-1];
      assign w_sign = r_sign[k-1];
    end

    // A stage may load when it is empty or its contents move on this cycle.
    if (k == CNT_W - 1) begin : g_last_adv
      assign w_adv[k] = !r_v[k] || out_ready;
    end else begin : g_mid_adv
      assign w_adv[k] = !r_v[k] || w_adv[k+1];
    end

    shift_rotate_stage #(
      .WIDTH (WIDTH),
      .AMT   (2 ** k)
    ) u_stage (
      .i_data   (w_src),
      .i_op     (w_op),
      .i_sign   (w_sign),
      .i_bit_en (w_cnt[k] && !w_err),
      .o_data   (w_moved)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]    <= 1'b0;
        r_data[k] <= '0;
        r_op[k]   <= '0;
        r_cnt[k]  <= '0;
        r_tag[k]  <= '0;
        r_err[k]  <= 1'b0;
        r_sign[k] <= 1'b0;
      end else if (w_adv[k]) begin
        r_v[k]    <= w_v;
        r_data[k] <= w_moved;
        r_op[k]   <= w_op;
        r_cnt[k]  <= w_cnt;
        r_tag[k]  <= w_tag;
        r_err[k]  <= w_err;
        r_sign[k] <= w_sign;
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[CNT_W-1];
  assign out_data  = r_data[CNT_W-1];
  assign out_tag   = r_tag[CNT_W-1];
  assign out_err   = r_err[CNT_W-1];

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed vectors and handshake sequences on a 16-bit unit, plus randomized
// scoreboard runs on 8/16/32-bit units against an arithmetic reference model.
module tb_shift_rotate_pipe;
  import shift_rotate_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rnd_done = 0;

  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] din, input int c);
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    d    = din & mask;
    case (op)
      OP_ROL:  r = (d << c) | (d >> (w - c));
      OP_SLL:  r = d << c;
      OP_ROR:  r = (d >> c) | (d << (w - c));
      OP_SRL:  r = d >> c;
      OP_SRA:  r = d[w-1] ? ((d >> c) | (mask & ~(mask >> c))) : (d >> c);
      default: r = d;
    endcase
    return r & mask;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  shift_rotate_pipe #(.WIDTH(16), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_cnt(in_cnt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  // Latency counts cycles from the handshake cycle to the first cycle out_valid is seen.
  task automatic send_one(input logic [2:0] op, input logic [15:0] d,
                          input logic [3:0] c, input logic [3:0] t, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_cnt = c; in_tag = t; out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[16];
    exp_t dq[$];
    exp_t e;
    int   lat, acc, seen, first_cyc, n_out;
    logic [15:0] held_d;
    logic [3:0]  held_t;

    vecs[0]  = '{OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b0};
    vecs[1]  = '{OP_ROR, 16'h0001, 4'd4,  16'h1000, 1'b0};
    vecs[2]  = '{OP_SRL, 16'h8000, 4'd15, 16'h0001, 1'b0};
    vecs[3]  = '{OP_SRA, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
    vecs[4]  = '{OP_SLL, 16'hFFFF, 4'd0,  16'hFFFF, 1'b0};
    vecs[5]  = '{3'b110, 16'h1234, 4'd3,  16'h1234, 1'b1};
    vecs[6]  = '{OP_SLL, 16'h0001, 4'd15, 16'h8000, 1'b0};
    vecs[7]  = '{OP_SRA, 16'h7FFF, 4'd3,  16'h0FFF, 1'b0};
    vecs[8]  = '{OP_ROL, 16'h1234, 4'd8,  16'h3412, 1'b0};
    vecs[9]  = '{OP_ROR, 16'h8000, 4'd15, 16'h0001, 1'b0};
    vecs[10] = '{OP_SRL, 16'h1234, 4'd4,  16'h0123, 1'b0};
    vecs[11] = '{3'b101, 16'hABCD, 4'd5,  16'hABCD, 1'b1};
    vecs[12] = '{3'b111, 16'h5555, 4'd0,  16'h5555, 1'b1};
    vecs[13] = '{OP_SRA, 16'h9000, 4'd2,  16'hE400, 1'b0};
    vecs[14] = '{OP_ROL, 16'h8000, 4'd15, 16'h4000, 1'b0};
    vecs[15] = '{OP_ROR, 16'h1234, 4'd12, 16'h2341, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_data = '0; in_cnt = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_tag",   64'(out_tag),   64'd0);
    chk("reset_out_err",   64'(out_err),   64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      send_one(vecs[i].op, vecs[i].data, vecs[i].cnt, 4'(i), lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i));
      chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].exp_err));
    end

    // Streaming: 8 back-to-back ops, results must emerge on consecutive cycles.
    out_ready = 1'b1; first_cyc = -1; n_out = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        in_valid = 1'b1; in_op = 3'(cyc % 5); in_data = 16'(16'h1357 * (cyc + 1));
        in_cnt = 4'(cyc * 3); in_tag = 4'(cyc);
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready)
        dq.push_back('{ref_model(16, in_op, 64'(in_data), int'(in_cnt)), in_tag, 1'b0});
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("stream_gapless", 64'(cyc - first_cyc), 64'(n_out));
        chk("stream_tag", 64'(out_tag), 64'(n_out));
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk("stream_data", 64'(out_data), e.data);
        end else chk("stream_spurious", 64'd1, 64'd0);
        n_out++;
      end
    end
    chk("stream_count", 64'(n_out), 64'd8);

    // Backpressure: fill with out_ready low, then verify the held output.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_SRA; in_data = 16'h8000 | 16'(acc * 16'h0111);
      in_cnt = 4'(acc + 1); in_tag = 4'(8 + acc);
      #1;
      if (!in_ready) break;
      dq.push_back('{ref_model(16, OP_SRA, 64'(in_data), int'(in_cnt)), in_tag, 1'b0});
      acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd4);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    held_d = out_data; held_t = out_tag;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'(held_d));
      chk("bp_hold_tag", 64'(out_tag), 64'(held_t));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end

    // Full pipe: accept and output in the same cycle.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = OP_ROR; in_data = 16'h00F0; in_cnt = 4'd4; in_tag = 4'd12;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) dq.push_back('{ref_model(16, OP_ROR, 64'h00F0, 4), 4'd12, 1'b0});
    for (int i = 0; i < 20 && dq.size() > 0; i++) begin
      if (i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
      end
      if (out_valid) begin
        e = dq.pop_front();
        chk("drain_data", 64'(out_data), e.data);
        chk("drain_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    in_valid = 1'b0;
    chk("drain_all", 64'(dq.size()), 64'd0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_SLL; in_data = 16'h0F0F; in_cnt = 4'(i); in_tag = 4'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_ghost", 64'(seen), 64'd0);
    send_one(OP_ROL, 16'h8001, 4'd1, 4'hA, lat);
    chk("postrst_latency", 64'(lat), 64'd4);
    chk("postrst_data", 64'(out_data), 64'h0003);
    chk("postrst_tag", 64'(out_tag), 64'hA);

    for (int i = 0; i < 5000 && rnd_done < 3; i++) @(negedge clk);
    chk("rnd_complete", 64'(rnd_done), 64'd3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W  = 8 << gi;
    localparam int CW = $clog2(W);
    logic          rrst_n, iv, ir, ov, ordy, oe;
    logic [2:0]    op;
    logic [W-1:0]  d, od;
    logic [CW-1:0] c;
    logic [3:0]    t, ot;
    exp_t          q[$];

    shift_rotate_pipe #(.WIDTH(W), .TAG_W(4)) u_rdut (
      .clk(clk), .rst_n(rrst_n),
      .in_valid(iv), .in_ready(ir), .in_op(op), .in_data(d), .in_cnt(c), .in_tag(t),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(ot), .out_err(oe)
    );

    initial begin
      exp_t e;
      rrst_n = 1'b0; iv = 1'b0; ordy = 1'b0; op = '0; d = '0; c = '0; t = '0;
      repeat (3) @(negedge clk);
      rrst_n = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
        @(negedge clk);
        iv   = (cyc < 500) && ($urandom_range(0, 3) != 0);
        op   = 3'($urandom_range(0, 7));
        d    = W'($urandom);
        c    = CW'($urandom);
        t    = 4'($urandom);
        ordy = (cyc >= 500) || ($urandom_range(0, 2) != 0);
        #1;
        if (iv && ir) q.push_back('{ref_model(W, op, 64'(d), int'(c)), t, (op > OP_SRA)});
        if (ov && ordy) begin
          if (q.size() == 0) chk($sformatf("rnd%0d_spurious", W), 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_data", W), 64'(od), e.data);
            chk($sformatf("rnd%0d_tag", W), 64'(ot), 64'(e.tag));
            chk($sformatf("rnd%0d_err", W), 64'(oe), 64'(e.err));
          end
        end
      end
      iv = 1'b0;
      chk($sformatf("rnd%0d_drained", W), 64'(q.size()), 64'd0);
      rnd_done++;
    end
  end

endmodule
